// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Access size encodings as produced by the decoder (memDataSize).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte-enable patterns before shifting to the addressed lane.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } arb_state_t;

    // True when the access cannot be performed at this byte offset.
    // The reserved size code is always rejected.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: f_misaligned = 1'b0;
            SZ_HALF: f_misaligned = off[0];
            SZ_WORD: f_misaligned = |off;
            default: f_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store enables/replication and load extract/extend.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    // Store path: shift the enable pattern to the lane, replicate data across lanes.
    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        case (i_size)
            SZ_BYTE: begin
                o_be    = BE_BYTE << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = BE_HALF << i_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                o_be    = BE_WORD;
                o_wdata = i_wdata;
            end
            default: begin
                o_be    = '0;
                o_wdata = '0;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then zero/sign extend.
    always_comb begin
        w_lane  = i_rdata >> {i_off, 3'b000};
        o_rdata = '0;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
            SZ_HALF: o_rdata = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
            SZ_WORD: o_rdata = i_rdata;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_r0.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
module mem_arbiter_r0
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_signed,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall
);

    localparam int unsigned     CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_CNT = CW'(TIMEOUT);

    arb_state_t      r_state, w_state_next;
    logic            r_last_data;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic            r_sgn;
    logic            r_we;

    logic            w_if_elig, w_d_elig, w_pick_f, w_pick_d;
    logic            w_grant_f, w_grant_d, w_bad, w_done, w_abort, w_to;
    logic [1:0]      w_la_size, w_la_off;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata, w_rdata_ext;

    // A requester showing its valid pulse this cycle is still holding the old request.
    assign w_if_elig = if_req & ~if_valid;
    assign w_d_elig  = d_req & ~d_valid;
    assign w_pick_f  = w_if_elig & (~w_d_elig | r_last_data);
    assign w_pick_d  = w_d_elig & ~w_pick_f;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_to      = (TIMEOUT != 0) && (w_cnt_inc == TO_CNT);

    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

    // The single lane aligner serves store steering at grant and load extraction at ack.
    assign w_la_size = (r_state == IDLE) ? d_size : r_size;
    assign w_la_off  = (r_state == IDLE) ? d_addr[1:0] : r_off;

    mem_lane_align u_align (
        .i_size   (w_la_size),
        .i_off    (w_la_off),
        .i_signed (r_sgn),
        .i_wdata  (d_wdata),
        .i_rdata  (mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Next state plus one-cycle control strobes for the datapath registers.
    always_comb begin
        w_state_next = r_state;
        w_grant_f    = 1'b0;
        w_grant_d    = 1'b0;
        w_bad        = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_f) begin
                    w_grant_f = 1'b1;
                    w_bad     = f_misaligned(SZ_WORD, if_addr[1:0]);
                    if (!w_bad) w_state_next = FETCH;
                end else if (w_pick_d) begin
                    w_grant_d = 1'b1;
                    w_bad     = f_misaligned(d_size, d_addr[1:0]);
                    if (!w_bad) w_state_next = DATA;
                end
            end
            FETCH, DATA: begin
                w_done  = mem_ack;
                w_abort = ~mem_ack & w_to;
                if (w_done || w_abort) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Registered outputs, memory port, fairness flag and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata    <= '0;
            if_valid    <= 1'b0;
            if_err      <= 1'b0;
            d_rdata     <= '0;
            d_valid     <= 1'b0;
            d_err       <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            r_last_data <= 1'b0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_off       <= '0;
            r_sgn       <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;

            if (w_grant_f || w_grant_d) begin
                r_last_data <= w_grant_d;
                r_cnt       <= '0;
            end else if (r_state != IDLE && !w_done && !w_abort) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_grant_f) begin
                if (w_bad) begin
                    if_valid <= 1'b1;
                    if_err   <= 1'b1;
                    if_rdata <= '0;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be    <= BE_WORD;
                    mem_wdata <= '0;
                end
            end

            if (w_grant_d) begin
                if (w_bad) begin
                    d_valid <= 1'b1;
                    d_err   <= 1'b1;
                    d_rdata <= '0;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= d_we;
                    mem_addr  <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be    <= d_we ? w_be : BE_WORD;
                    mem_wdata <= d_we ? w_wdata : '0;
                    r_size    <= d_size;
                    r_off     <= d_addr[1:0];
                    r_sgn     <= d_signed;
                    r_we      <= d_we;
                end
            end

            if (w_done || w_abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (r_state == FETCH) begin
                    if_valid <= 1'b1;
                    if_err   <= w_abort;
                    if_rdata <= w_done ? mem_rdata : '0;
                end else begin
                    d_valid <= 1'b1;
                    d_err   <= w_abort;
                    d_rdata <= (w_done && !r_we) ? w_rdata_ext : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_r0.sv
// Directed self-checking bench for mem_arbiter_r0 (TIMEOUT reduced to 4).
module tb_mem_arbiter_r0;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;

    int          n_cmp;
    int          n_err;

    logic        resp_en;
    logic        stray_ack;
    logic [31:0] rdata_val;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    int          lat;
    int          reqcyc;
    logic [31:0] rd;
    logic        er;
    logic        twice;
    logic [7:0]  d_hist;
    logic [7:0]  i_hist;

    mem_arbiter_r0 #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_signed  (d_signed),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Zero-wait memory: acks at the falling edge of the first mem_req cycle.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray_ack) begin
                mem_ack   = 1'b1;
                stray_ack = 1'b0;
            end else if (resp_en && mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_val;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Issue one request (entered just after a rising edge) and wait for its completion.
    task automatic do_access(input bit fetch, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic sgn, input logic [31:0] wdata);
        lat    = 99;
        reqcyc = 0;
        rd     = '0;
        er     = 1'b0;
        twice  = 1'b0;
        if (fetch) begin
            if_addr = addr;
            if_req  = 1'b1;
        end else begin
            d_we     = we;
            d_addr   = addr;
            d_size   = size;
            d_signed = sgn;
            d_wdata  = wdata;
            d_req    = 1'b1;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                if (reqcyc == 0) begin
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_be    = mem_be;
                    cap_wdata = mem_wdata;
                end
                reqcyc++;
            end
            if (fetch ? if_valid : d_valid) begin
                lat = c;
                rd  = fetch ? if_rdata : d_rdata;
                er  = fetch ? if_err : d_err;
                break;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clk); #1;
        twice = fetch ? if_valid : d_valid;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_size    = 2'b00;
        d_signed  = 1'b0;
        resp_en   = 1'b1;
        stray_ack = 1'b0;
        rdata_val = '0;
        cap_we    = 1'b0;
        cap_addr  = '0;
        cap_be    = '0;
        cap_wdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Loads with lane extraction and extension
        rdata_val = 32'h80FF_FF7F;
        do_access(1'b0, 1'b0, 32'h103, 2'b00, 1'b1, 32'h0);
        check("lb_s_rdata", rd, 32'hFFFF_FF80);
        check("lb_s_addr", cap_addr, 32'h100);
        check("lb_s_we", 32'(cap_we), 32'd0);
        check("lb_s_lat", 32'(lat), 32'd2);
        check("lb_s_err", 32'(er), 32'd0);
        check("lb_s_single", 32'(twice), 32'd0);
        do_access(1'b0, 1'b0, 32'h103, 2'b00, 1'b0, 32'h0);
        check("lb_u_rdata", rd, 32'h0000_0080);
        do_access(1'b0, 1'b0, 32'h102, 2'b01, 1'b1, 32'h0);
        check("lh_s_rdata", rd, 32'hFFFF_80FF);
        do_access(1'b0, 1'b0, 32'h100, 2'b01, 1'b0, 32'h0);
        check("lh_u_rdata", rd, 32'h0000_FF7F);
        do_access(1'b0, 1'b0, 32'h100, 2'b10, 1'b1, 32'h0);
        check("lw_rdata", rd, 32'h80FF_FF7F);

        // Stores: lane enables and replication
        do_access(1'b0, 1'b1, 32'h202, 2'b01, 1'b0, 32'h0000_BEEF);
        check("sh_be", 32'(cap_be), 32'h0000_000C);
        check("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_we", 32'(cap_we), 32'd1);
        check("sh_addr", cap_addr, 32'h200);
        check("sh_lat", 32'(lat), 32'd2);
        do_access(1'b0, 1'b1, 32'h301, 2'b00, 1'b0, 32'h1234_56A5);
        check("sb_be", 32'(cap_be), 32'h0000_0002);
        check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        do_access(1'b0, 1'b1, 32'h400, 2'b10, 1'b0, 32'h1234_5678);
        check("sw_be", 32'(cap_be), 32'h0000_000F);
        check("sw_wdata", cap_wdata, 32'h1234_5678);

        // Misaligned and reserved-size accesses never reach memory
        do_access(1'b0, 1'b0, 32'h006, 2'b10, 1'b0, 32'h0);
        check("mis_w_lat", 32'(lat), 32'd1);
        check("mis_w_err", 32'(er), 32'd1);
        check("mis_w_req", 32'(reqcyc), 32'd0);
        check("mis_w_rdata", rd, 32'h0);
        do_access(1'b0, 1'b0, 32'h100, 2'b11, 1'b0, 32'h0);
        check("rsv_lat", 32'(lat), 32'd1);
        check("rsv_err", 32'(er), 32'd1);
        check("rsv_req", 32'(reqcyc), 32'd0);
        do_access(1'b0, 1'b0, 32'h101, 2'b01, 1'b0, 32'h0);
        check("mis_h_err", 32'(er), 32'd1);
        do_access(1'b1, 1'b0, 32'h042, 2'b00, 1'b0, 32'h0);
        check("mis_f_err", 32'(er), 32'd1);
        check("mis_f_req", 32'(reqcyc), 32'd0);

        // Timeout: no ack, then a normal fetch
        resp_en = 1'b0;
        do_access(1'b1, 1'b0, 32'h500, 2'b00, 1'b0, 32'h0);
        check("to_reqcyc", 32'(reqcyc), 32'd4);
        check("to_lat", 32'(lat), 32'd5);
        check("to_err", 32'(er), 32'd1);
        check("to_rdata", rd, 32'h0);
        check("to_req_low", 32'(mem_req), 32'd0);
        resp_en   = 1'b1;
        rdata_val = 32'hCAFE_F00D;
        do_access(1'b1, 1'b0, 32'h504, 2'b00, 1'b0, 32'h0);
        check("f_rdata", rd, 32'hCAFE_F00D);
        check("f_err", 32'(er), 32'd0);
        check("f_lat", 32'(lat), 32'd2);
        check("f_addr", cap_addr, 32'h504);

        // Ack while idle is ignored
        stray_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stray_d_valid", 32'(d_valid), 32'd0);
        check("stray_if_valid", 32'(if_valid), 32'd0);
        check("stray_req", 32'(mem_req), 32'd0);

        // Contention: last grant was fetch, so data goes first, then alternation
        rdata_val = 32'h1122_3344;
        if_addr   = 32'h40;
        d_addr    = 32'h80;
        d_we      = 1'b0;
        d_size    = 2'b10;
        d_signed  = 1'b0;
        if_req    = 1'b1;
        d_req     = 1'b1;
        d_hist    = '0;
        i_hist    = '0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            d_hist[e] = d_valid;
            i_hist[e] = if_valid;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("alt_d_pulses", 32'(d_hist), 32'h0000_0022);
        check("alt_if_pulses", 32'(i_hist), 32'h0000_0088);
        check("alt_if_rdata", if_rdata, 32'h1122_3344);
        check("alt_d_rdata", d_rdata, 32'h1122_3344);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("alt_idle_req", 32'(mem_req), 32'd0);
        check("alt_idle_stall", 32'(stall), 32'd0);

        // Reset while a data access waits on memory
        resp_en  = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h600;
        d_size   = 2'b10;
        d_signed = 1'b0;
        d_req    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rm_req_before", 32'(mem_req), 32'd1);
        check("rm_stall", 32'(stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rm_req_async", 32'(mem_req), 32'd0);
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            check("rm_no_valid", 32'(d_valid), 32'd0);
        end
        rdata_val = 32'h0BAD_BEEF;
        resp_en   = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (d_valid) begin
                lat = c;
                break;
            end
        end
        check("rm_lat", 32'(lat), 32'd2);
        check("rm_rdata", d_rdata, 32'h0BAD_BEEF);
        check("rm_err", 32'(d_err), 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        check("rm_single", 32'(d_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
